hand_sorter: RTL
================

Name: hand_sorter

Overview:
- Serial-in card collector and sorter that sits directly upstream of the hand evaluator.
- Accepts one 6-bit card per handshake until NCARDS cards (2 hole + 5 board) are held.
- Keeps the held cards sorted by descending rank on every insertion.
- Presents the sorted 42-bit hand with a valid/ready handshake; highest card is in bits [41:36], the evaluator's required input ordering.

Parameters:
NCARDS, 7, cards per hand; output width is 6*NCARDS.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
clear  input  1  synchronous abort; discards the partial/held hand
in_valid  input  1  in_card is valid this cycle
in_card  input  6  card {suit[1:0], rank[3:0]}; suit C=00 H=01 S=10 D=11; rank 2..14 (A=14)
in_ready  output  1  block can accept a card
out_valid  output  1  sorted hand available
out_ready  input  1  consumer takes the hand
out_hand  output  6*NCARDS  sorted cards; slot0 at [6*NCARDS-1 -: 6], descending rank
out_err  output  1  hand contains an illegal rank (outside 2..14)
out_dup  output  1  hand contains an identical 6-bit card twice

Behaviour:
- Reset (rst high, asynchronous): state=COLLECT, count=0, all slots=6'h00, in_ready=1, out_valid=0, out_hand=0, out_err=0, out_dup=0.
- FSM has two states, COLLECT and HOLD.
- COLLECT:
  - in_ready=1 and out_valid=0.
  - An accept occurs when in_valid=1 on a rising edge.
  - On each accept, count increments (3 bits, 0..NCARDS) and the card is inserted in one cycle.
  - When the accept makes count==NCARDS, next state is HOLD.
- HOLD:
  - in_ready=0 and out_valid=1; out_hand, out_err and out_dup are stable.
  - in_valid is ignored.
  - out_valid and out_ready high together at a rising edge: slots cleared to 0, count=0, flags cleared, return to COLLECT.
  - No card is accepted in that same cycle.
- Latency: out_valid rises on the edge after the last accept (1 cycle). Backpressure is unbounded.
- Insertion, slot0 = highest:
  - p = number of occupied slots (index < count) whose rank >= new rank.
  - Slots i<p are unchanged, slot p = new card, slots i>p take the old slot i-1.
  - Equal ranks are stable: an earlier-arrived card sits above a later one.
  - Empty slots hold 0 and are never compared.
- out_err: sticky; set when an accepted card has rank <2 or >14. The card is still inserted and counted, using its raw rank.
- out_dup: sticky; set when an accepted card equals any occupied slot exactly (all 6 bits).
- clear: synchronous, takes effect in any state and wins over a simultaneous accept or output handshake. Result is the reset values (but synchronous).
- rst asserted mid-collect or in HOLD: hand lost immediately; out_valid drops asynchronously.
- Rank arithmetic is 4-bit unsigned compare only; no suit participates in ordering.

Decomposition:
- Shared package (card_pkg) holds:
  - card field widths (CARD_W=6, RANK_W=4, SUIT_W=2);
  - suit codes C/H/S/D;
  - rank constants TWO..A;
  - RANK_MIN=2 and RANK_MAX=14.
- One natural sub-module: sort_insert. It is purely combinational: (slots, count, new card) -> next slots plus dup flag.
- The FSM, counter and flags stay in hand_sorter.

Test Plan:
- Basic sort:
  - stimulus: after reset, feed 02,3E,17,2D,07,2A,35 back-to-back with out_ready=0.
  - response: out_valid rises one cycle after the 7th accept; slots0..6 = 3E,2D,2A,17,07,35,02; err=0, dup=0; in_ready=0.
- Backpressure:
  - stimulus: hold out_ready=0 for 20 cycles, toggle in_valid with junk, then pulse out_ready.
  - response: out_hand is unchanged throughout; next cycle out_valid=0, in_ready=1, out_hand=0.
- Stability:
  - stimulus: feed 0C,3C,1C,2C,0E,05,25 (four queens C,D,H,S; AC; 5C; 5S).
  - response: slots = 0E,0C,3C,1C,2C,05,25.
- Flags:
  - stimulus: feed 3E twice plus 5 valid cards, one with rank 0xF (e.g. 0F).
  - response: out_dup=1 and out_err=1 in HOLD; both are 0 after the handshake.
- Clear/reset mid-operation:
  - stimulus: accept 3 cards, assert clear for one cycle together with in_valid, then feed 7 cards.
  - response: the first 3 cards are absent, out_valid appears only after 7 new accepts.
  - stimulus: assert rst asynchronously between edges while in HOLD.
  - response: out_valid falls without waiting for a clock edge.

Source files
------------

// File: rtl/card_pkg.sv
// Shared card definitions for the hand sorter slice.
// Holds card field widths, suit codes, rank constants, the sorter FSM
// state type and small helpers for pulling apart a {suit, rank} card.
package card_pkg;

  localparam int CARD_W = 6;
  localparam int RANK_W = 4;
  localparam int SUIT_W = 2;

  localparam logic [SUIT_W-1:0] SUIT_C = 2'b00;
  localparam logic [SUIT_W-1:0] SUIT_H = 2'b01;
  localparam logic [SUIT_W-1:0] SUIT_S = 2'b10;
  localparam logic [SUIT_W-1:0] SUIT_D = 2'b11;

  localparam logic [RANK_W-1:0] RANK_TWO   = 4'd2;
  localparam logic [RANK_W-1:0] RANK_THREE = 4'd3;
  localparam logic [RANK_W-1:0] RANK_FOUR  = 4'd4;
  localparam logic [RANK_W-1:0] RANK_FIVE  = 4'd5;
  localparam logic [RANK_W-1:0] RANK_SIX   = 4'd6;
  localparam logic [RANK_W-1:0] RANK_SEVEN = 4'd7;
  localparam logic [RANK_W-1:0] RANK_EIGHT = 4'd8;
  localparam logic [RANK_W-1:0] RANK_NINE  = 4'd9;
  localparam logic [RANK_W-1:0] RANK_TEN   = 4'd10;
  localparam logic [RANK_W-1:0] RANK_J     = 4'd11;
  localparam logic [RANK_W-1:0] RANK_Q     = 4'd12;
  localparam logic [RANK_W-1:0] RANK_K     = 4'd13;
  localparam logic [RANK_W-1:0] RANK_A     = 4'd14;

  localparam logic [RANK_W-1:0] RANK_MIN = RANK_TWO;
  localparam logic [RANK_W-1:0] RANK_MAX = RANK_A;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_e;

  // Rank field of a card; ordering uses this alone, never the suit.
  function automatic logic [RANK_W-1:0] card_rank(input logic [CARD_W-1:0] card);
    return card[RANK_W-1:0];
  endfunction

  // True when a raw rank lies outside 2..14.
  function automatic logic rank_illegal(input logic [RANK_W-1:0] rank);
    return (rank < RANK_MIN) || (rank > RANK_MAX);
  endfunction

endpackage

// File: rtl/hand_sorter_if.sv
// Card-in / hand-out handshake bundle for hand_sorter.
// Signals: clear (sync abort), in_valid/in_card/in_ready (card input),
// out_valid/out_ready/out_hand/out_err/out_dup (sorted hand output).
// slave = the sorter, master = the producer/consumer driving it.
interface hand_sorter_if
  import card_pkg::*;
#(
  parameter int NCARDS = 7
);
  logic                     clear;
  logic                     in_valid;
  logic [CARD_W-1:0]        in_card;
  logic                     in_ready;
  logic                     out_valid;
  logic                     out_ready;
  logic [CARD_W*NCARDS-1:0] out_hand;
  logic                     out_err;
  logic                     out_dup;

  modport slave (
    input  clear, in_valid, in_card, out_ready,
    output in_ready, out_valid, out_hand, out_err, out_dup
  );

  modport master (
    output clear, in_valid, in_card, out_ready,
    input  in_ready, out_valid, out_hand, out_err, out_dup
  );
endinterface

// File: rtl/sort_insert.sv
// Combinational single-card insertion into a descending-rank slot list.
// Ports: slots (current slots, index 0 = highest), count (occupied slots),
// card (new card) -> next_slots (list with card inserted), dup (card
// exactly matches an occupied slot).
module sort_insert
  import card_pkg::*;
#(
  parameter int NCARDS = 7,
  parameter int CNT_W  = $clog2(NCARDS + 1)
) (
  input  logic [NCARDS-1:0][CARD_W-1:0] slots,
  input  logic [CNT_W-1:0]              count,
  input  logic [CARD_W-1:0]             card,
  output logic [NCARDS-1:0][CARD_W-1:0] next_slots,
  output logic                          dup
);

  logic [CNT_W-1:0]              pos_s;
  logic [NCARDS-1:0][CARD_W-1:0] shifted_s;

  // Every slot moved down by one; used for slots below the insert point.
  assign shifted_s = {slots[NCARDS-2:0], {CARD_W{1'b0}}};

  // Insert position = occupied slots ranking >= new card (keeps ties in
  // arrival order); duplicate check against occupied slots only.
  always_comb begin
    pos_s = {CNT_W{1'b0}};
    dup   = 1'b0;
    for (int i = 0; i < NCARDS; i++) begin
      if (CNT_W'(i) < count) begin
        if (card_rank(slots[i]) >= card_rank(card)) begin
          pos_s = pos_s + CNT_W'(1);
        end else begin
          pos_s = pos_s;
        end
        if (slots[i] == card) begin
          dup = 1'b1;
        end else begin
          dup = dup;
        end
      end else begin
        pos_s = pos_s;
      end
    end
  end

  // Build the new slot list around the insert position.
  always_comb begin
    next_slots = slots;
    for (int i = 0; i < NCARDS; i++) begin
      if (CNT_W'(i) < pos_s) begin
        next_slots[i] = slots[i];
      end else if (CNT_W'(i) == pos_s) begin
        next_slots[i] = card;
      end else begin
        next_slots[i] = shifted_s[i];
      end
    end
  end

endmodule

// File: rtl/hand_sorter.sv
// Serial card collector / sorter feeding the hand evaluator.
// Ports: clk, rst (async active-high), bus (hand_sorter_if.slave):
// accepts one card per in_valid cycle while collecting, keeps the cards
// sorted by descending rank, then holds the full hand on out_hand
// (slot0 in the top 6 bits) with out_valid until out_ready.
// out_err / out_dup are sticky flags for illegal ranks and duplicates.
module hand_sorter
  import card_pkg::*;
#(
  parameter int NCARDS = 7
) (
  input  logic          clk,
  input  logic          rst,
  hand_sorter_if.slave  bus
);

  localparam int               CNT_W = $clog2(NCARDS + 1);
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(NCARDS);

  state_e                        state_r, state_s;
  logic [CNT_W-1:0]              count_r, count_s;
  logic [NCARDS-1:0][CARD_W-1:0] slots_r, slots_s;
  logic                          err_r, err_s;
  logic                          dup_r, dup_s;

  logic [NCARDS-1:0][CARD_W-1:0] ins_slots_s;
  logic                          ins_dup_s;
  logic [CNT_W-1:0]              count_inc_s;
  logic [CARD_W*NCARDS-1:0]      out_hand_s;

  sort_insert #(
    .NCARDS (NCARDS),
    .CNT_W  (CNT_W)
  ) u_sort_insert (
    .slots      (slots_r),
    .count      (count_r),
    .card       (bus.in_card),
    .next_slots (ins_slots_s),
    .dup        (ins_dup_s)
  );

  assign count_inc_s = count_r + CNT_W'(1);

  // Next-state logic: collect cards, hold the hand, clear wins over all.
  always_comb begin
    state_s = state_r;
    count_s = count_r;
    slots_s = slots_r;
    err_s   = err_r;
    dup_s   = dup_r;
    case (state_r)
      COLLECT: begin
        if (bus.in_valid) begin
          slots_s = ins_slots_s;
          count_s = count_inc_s;
          err_s   = err_r | rank_illegal(card_rank(bus.in_card));
          dup_s   = dup_r | ins_dup_s;
          if (count_inc_s == FULL) begin
            state_s = HOLD;
          end else begin
            state_s = COLLECT;
          end
        end else begin
          state_s = COLLECT;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_s = COLLECT;
          count_s = {CNT_W{1'b0}};
          slots_s = '0;
          err_s   = 1'b0;
          dup_s   = 1'b0;
        end else begin
          state_s = HOLD;
        end
      end
      default: begin
        state_s = COLLECT;
        count_s = {CNT_W{1'b0}};
        slots_s = '0;
        err_s   = 1'b0;
        dup_s   = 1'b0;
      end
    endcase
    if (bus.clear) begin
      state_s = COLLECT;
      count_s = {CNT_W{1'b0}};
      slots_s = '0;
      err_s   = 1'b0;
      dup_s   = 1'b0;
    end else begin
      state_s = state_s;
    end
  end

  // State, count, slot and flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= COLLECT;
      count_r <= {CNT_W{1'b0}};
      slots_r <= '0;
      err_r   <= 1'b0;
      dup_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      count_r <= count_s;
      slots_r <= slots_s;
      err_r   <= err_s;
      dup_r   <= dup_s;
    end
  end

  // Flatten slots so slot0 lands in the most significant card position.
  always_comb begin
    out_hand_s = '0;
    for (int i = 0; i < NCARDS; i++) begin
      out_hand_s[CARD_W*(NCARDS-1-i) +: CARD_W] = slots_r[i];
    end
  end

  assign bus.in_ready  = (state_r == COLLECT);
  assign bus.out_valid = (state_r == HOLD);
  assign bus.out_hand  = out_hand_s;
  assign bus.out_err   = err_r;
  assign bus.out_dup   = dup_r;

endmodule
